// File: rtl/dmem_ctrl.sv
// Data memory controller: one RV32I load/store at a time, byte lanes, sign/zero extension, fault flags.
// Latency: request accepted at edge k -> rsp_valid high for one cycle after edge k+1+WAIT_STATES.
// Backpressure: req_ready only in IDLE; responses cannot be stalled (single-cycle rsp_valid pulse).
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   req_valid/req_ready                request handshake
//   req_we, req_funct3, req_addr,      request fields (store flag, RISC-V funct3, byte address,
//   req_wdata                          right-aligned store data)
//   rsp_valid, rsp_rdata, rsp_err      response pulse, extended load data, fault flag (held until next response)
//   load_cnt, store_cnt, err_cnt       performance counters, present only when DMEM_PERF_CNT_EN is defined
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_PERF_CNT_EN
   ,output logic [31:0] load_cnt,
    output logic [31:0] store_cnt,
    output logic [31:0] err_cnt
`endif
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept, access;

    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] widx;
    logic [31:0]   rd_word, lane_word, ld_data, wlane;
    logic [3:0]    be;
    logic          oor, bad_f3, misaligned, bad_store, acc_err, do_write;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);

    // Request latch: datapath only, contents irrelevant outside BUSY.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // ---------------- Fault classification ----------------
    always_comb begin
        oor        = {2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS);
        bad_f3     = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111);
        misaligned = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                     ((f3_q == 3'b010) && (addr_q[1:0] != 2'b00));
        // Unsigned variants exist only for loads.
        bad_store  = we_q && f3_q[2];
        acc_err    = oor || bad_f3 || misaligned || bad_store;
    end

    assign widx = addr_q[AW+1:2];

    // ---------------- Load path ----------------
    always_comb begin
        rd_word   = mem[widx];
        lane_word = rd_word >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  ld_data = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b001:  ld_data = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {24'd0, lane_word[7:0]};
            3'b101:  ld_data = {16'd0, lane_word[15:0]};
            default: ld_data = 32'd0;
        endcase
    end

    // ---------------- Store path ----------------
    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_q[1:0];
                wlane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
        endcase
        // A reset landing on the commit edge must suppress the write.
        do_write = access && we_q && !acc_err && rst_n;
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    // ---------------- Response registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (access) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || we_q) ? 32'd0 : ld_data;
        end
    end

`ifdef DMEM_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_cnt  <= '0;
            store_cnt <= '0;
            err_cnt   <= '0;
        end else if (access) begin
            if (acc_err)   err_cnt   <= err_cnt + 32'd1;
            else if (we_q) store_cnt <= store_cnt + 32'd1;
            else           load_cnt  <= load_cnt + 32'd1;
        end
    end
`endif

endmodule
